// File: rtl/scsdpram_pipe_pkg.sv
// Shared constants and helpers for the pipelined byte-enable SDP RAM.
package scsdpram_pipe_pkg;

   // Legal read-latency window
   localparam int unsigned C_LAT_MIN = 1;
   localparam int unsigned C_LAT_MAX = 3;

   // ceil(log2(n)), never below 1 so a 2-word RAM still has an address bit
   function automatic int unsigned clog2s(input int unsigned n);
      int unsigned r;
      r = 1;
      while ((2 ** r) < n) r = r + 1;
      return r;
   endfunction

   // Number of write-enable lanes in a word
   function automatic int unsigned lane_count(input int unsigned w, input int unsigned bw);
      return w / bw;
   endfunction

endpackage

// File: rtl/scsdpram_lane.sv
// One byte lane: plain single-clock SDP array with an unreset registered output.
// The forward select lets the top load same-cycle write data into the output flop.
module scsdpram_lane #(
   parameter int unsigned C_BYTE_WIDTH = 8,
   parameter int unsigned C_DEPTH      = 1024,
   parameter int unsigned C_AW         = 10
) (
   input  logic                    i_clk,
   input  logic                    i_rd_en,
   input  logic [C_AW-1:0]         i_rd_addr,
   input  logic                    i_fwd,
   input  logic                    i_wr_en,
   input  logic [C_AW-1:0]         i_wr_addr,
   input  logic [C_BYTE_WIDTH-1:0] i_wr_data,
   output logic [C_BYTE_WIDTH-1:0] o_rd_data
);

   logic [C_BYTE_WIDTH-1:0] r_mem [C_DEPTH];
   logic [C_BYTE_WIDTH-1:0] r_q;

   // Storage write and registered read (old data unless forwarded)
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
      if (i_rd_en) begin
         r_q <= i_fwd ? i_wr_data : r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_q;

endmodule

// File: rtl/scsdpram_pipe.sv
// Single-clock SDP RAM with byte enables, 1..3 cycle read pipeline,
// read-valid strobe and optional write-to-read forwarding on collision.
module scsdpram_pipe
   import scsdpram_pipe_pkg::*;
#(
   parameter int unsigned C_WIDTH      = 32,
   parameter int unsigned C_DEPTH      = 1024,
   parameter int unsigned C_BYTE_WIDTH = 8,
   parameter int unsigned C_RD_LATENCY = 1,
   parameter int unsigned C_BYPASS     = 1
) (
   input  logic                                        CLK,
   input  logic                                        RST,
   input  logic                                        RD1_EN,
   input  logic [clog2s(C_DEPTH)-1:0]                  RD1_ADDR,
   output logic [C_WIDTH-1:0]                          RD1_DATA,
   output logic                                        RD1_VALID,
   input  logic                                        WR1_EN,
   input  logic [clog2s(C_DEPTH)-1:0]                  WR1_ADDR,
   input  logic [C_WIDTH-1:0]                          WR1_DATA,
   input  logic [lane_count(C_WIDTH, C_BYTE_WIDTH)-1:0] WR1_BE
);

   localparam int unsigned C_AW    = clog2s(C_DEPTH);
   localparam int unsigned C_LANES = lane_count(C_WIDTH, C_BYTE_WIDTH);
   localparam logic        C_FWD   = (C_BYPASS != 0);

   // Reject illegal configurations at elaboration
   if ((C_RD_LATENCY < C_LAT_MIN) || (C_RD_LATENCY > C_LAT_MAX)) begin : g_bad_lat
      $fatal(1, "scsdpram_pipe: C_RD_LATENCY must be in 1..3");
   end
   if ((C_WIDTH % C_BYTE_WIDTH) != 0) begin : g_bad_width
      $fatal(1, "scsdpram_pipe: C_WIDTH must be a multiple of C_BYTE_WIDTH");
   end
   if (C_DEPTH < 2) begin : g_bad_depth
      $fatal(1, "scsdpram_pipe: C_DEPTH must be at least 2");
   end

   logic               w_rd_ok;
   logic               w_wr_ok;
   logic               w_rd_go;
   logic               w_wr_go;
   logic               w_hit;
   logic [C_WIDTH-1:0] w_lane_q;
   logic [C_WIDTH-1:0] w_s0_data;
   logic               r_s0_vld;
   logic               r_s0_zero;
   logic               w_vld [C_RD_LATENCY];
   logic [C_WIDTH-1:0] w_dat [C_RD_LATENCY];

   // Address range check; trivially true when the depth fills the address space
   if (C_DEPTH == (2 ** C_AW)) begin : g_pow2
      assign w_rd_ok = 1'b1;
      assign w_wr_ok = 1'b1;
   end else begin : g_npow2
      assign w_rd_ok = (32'(RD1_ADDR) < C_DEPTH);
      assign w_wr_ok = (32'(WR1_ADDR) < C_DEPTH);
   end

   assign w_rd_go = RD1_EN & ~RST;
   assign w_wr_go = WR1_EN & ~RST & w_wr_ok;
   assign w_hit   = w_rd_go & w_wr_go & (RD1_ADDR == WR1_ADDR);

   // Byte lanes; forwarding mux sits in front of each lane's output flop (stage 0)
   for (genvar i = 0; i < C_LANES; i++) begin : g_lane
      scsdpram_lane #(
         .C_BYTE_WIDTH (C_BYTE_WIDTH),
         .C_DEPTH      (C_DEPTH),
         .C_AW         (C_AW)
      ) u_lane (
         .i_clk     (CLK),
         .i_rd_en   (w_rd_go & w_rd_ok),
         .i_rd_addr (RD1_ADDR),
         .i_fwd     (C_FWD & w_hit & WR1_BE[i]),
         .i_wr_en   (w_wr_go & WR1_BE[i]),
         .i_wr_addr (WR1_ADDR),
         .i_wr_data (WR1_DATA[i*C_BYTE_WIDTH +: C_BYTE_WIDTH]),
         .o_rd_data (w_lane_q[i*C_BYTE_WIDTH +: C_BYTE_WIDTH])
      );
   end

   // Stage 0 valid and zero flag; zero covers reset and out-of-range reads
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_s0_vld  <= 1'b0;
         r_s0_zero <= 1'b1;
      end else begin
         r_s0_vld <= RD1_EN;
         if (RD1_EN) begin
            r_s0_zero <= ~w_rd_ok;
         end
      end
   end

   assign w_s0_data = r_s0_zero ? '0 : w_lane_q;
   assign w_vld[0]  = r_s0_vld;
   assign w_dat[0]  = w_s0_data;

   // Trailing stages 1..C_RD_LATENCY-1; data only advances behind a valid
   for (genvar k = 1; k < C_RD_LATENCY; k++) begin : g_stage
      logic               r_vld;
      logic [C_WIDTH-1:0] r_dat;

      // Shift one stage, cleared by reset
      always_ff @(posedge CLK) begin
         if (RST) begin
            r_vld <= 1'b0;
            r_dat <= '0;
         end else begin
            r_vld <= w_vld[k-1];
            if (w_vld[k-1]) begin
               r_dat <= w_dat[k-1];
            end
         end
      end

      assign w_vld[k] = r_vld;
      assign w_dat[k] = r_dat;
   end

   assign RD1_VALID = w_vld[C_RD_LATENCY-1];
   assign RD1_DATA  = w_dat[C_RD_LATENCY-1];

endmodule

// File: tb/tb_scsdpram_pipe.sv
// Scoreboard bench: three configurations share one stimulus stream; each has
// its own reference memory, expected-result queue and output monitor.
module tb_scsdpram_pipe;

   localparam int unsigned N_DUT = 3;
   localparam int unsigned P_LAT [N_DUT] = '{1, 2, 3};
   localparam int unsigned P_BYP [N_DUT] = '{1, 0, 1};
   localparam int unsigned P_DEP [N_DUT] = '{1024, 12, 12};

   typedef struct {
      logic [31:0] data;
      int          due;
      logic        use_c;
      logic [31:0] cexp;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_en = 1'b0;
   logic [9:0]  rd_addr = '0;
   logic        wr_en = 1'b0;
   logic [9:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [3:0]  wr_be = '0;
   logic        dir_use = 1'b0;
   logic [31:0] dir_exp [N_DUT];
   logic        done = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      localparam int unsigned L  = P_LAT[g];
      localparam int unsigned B  = P_BYP[g];
      localparam int unsigned D  = P_DEP[g];
      localparam int unsigned AW = $clog2(D);

      logic [31:0] rd_data;
      logic        rd_valid;
      logic [31:0] mem [16];
      exp_t        q [$];
      int          cyc = 0;
      int          rst_cyc = -1;
      logic [31:0] last = '0;
      logic        fin = 1'b0;

      scsdpram_pipe #(
         .C_WIDTH      (32),
         .C_DEPTH      (D),
         .C_BYTE_WIDTH (8),
         .C_RD_LATENCY (L),
         .C_BYPASS     (B)
      ) u_dut (
         .CLK       (clk),
         .RST       (rst),
         .RD1_EN    (rd_en),
         .RD1_ADDR  (rd_addr[AW-1:0]),
         .RD1_DATA  (rd_data),
         .RD1_VALID (rd_valid),
         .WR1_EN    (wr_en),
         .WR1_ADDR  (wr_addr[AW-1:0]),
         .WR1_DATA  (wr_data),
         .WR1_BE    (wr_be)
      );

      // Reference model: word memory plus read-then-write ordering per edge
      always @(posedge clk) begin
         exp_t e;
         cyc = cyc + 1;
         if (rst) begin
            q.delete();
            rst_cyc = cyc;
         end else begin
            if (rd_en) begin
               e.due   = cyc + int'(L) - 1;
               e.use_c = dir_use;
               e.cexp  = dir_exp[g];
               if (int'(rd_addr) >= int'(D)) begin
                  e.data = '0;
               end else begin
                  e.data = mem[rd_addr[3:0]];
                  if (B != 0 && wr_en && wr_addr == rd_addr)
                     for (int b = 0; b < 4; b++)
                        if (wr_be[b]) e.data[b*8 +: 8] = wr_data[b*8 +: 8];
               end
               q.push_back(e);
            end
            if (wr_en && int'(wr_addr) < int'(D))
               for (int b = 0; b < 4; b++)
                  if (wr_be[b]) mem[wr_addr[3:0]][b*8 +: 8] = wr_data[b*8 +: 8];
         end
      end

      // Monitor: pop on every valid, check latency and data, check hold otherwise
      always @(negedge clk) begin
         exp_t e;
         if (rst_cyc >= 0) begin
            if (cyc == rst_cyc) last = '0;
            if (rd_valid) begin
               n_checks++;
               if (q.size() == 0) begin
                  n_errors++;
                  $display("FAIL u%0d spurious_valid: got valid with data %h, want no valid (cyc %0d)", g, rd_data, cyc);
               end else begin
                  e = q.pop_front();
                  if (rd_data !== e.data || cyc != e.due) begin
                     n_errors++;
                     $display("FAIL u%0d read: got %h at cyc %0d, want %h at cyc %0d", g, rd_data, cyc, e.data, e.due);
                  end
                  if (e.use_c) begin
                     n_checks++;
                     if (rd_data !== e.cexp) begin
                        n_errors++;
                        $display("FAIL u%0d directed: got %h, want %h (cyc %0d)", g, rd_data, e.cexp, cyc);
                     end
                  end
                  last = e.data;
               end
            end else begin
               n_checks++;
               if (rd_data !== last) begin
                  n_errors++;
                  $display("FAIL u%0d hold: got %h, want %h (cyc %0d)", g, rd_data, last, cyc);
               end
               if (q.size() > 0 && q[0].due <= cyc) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL u%0d missing_valid: got none, want %h due cyc %0d", g, q[0].data, q[0].due);
                  void'(q.pop_front());
               end
            end
            if (done && !fin) begin
               fin = 1'b1;
               n_checks++;
               if (q.size() != 0) begin
                  n_errors++;
                  $display("FAIL u%0d leftover: got %0d outstanding reads, want 0", g, q.size());
               end
            end
         end
      end
   end

   // Advance one edge and return inputs to idle
   task automatic tick();
      @(posedge clk);
      #1;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      rst     = 1'b0;
      dir_use = 1'b0;
   endtask

   task automatic do_wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      tick();
   endtask

   task automatic do_rd(input logic [9:0] a, input logic [31:0] e0,
                        input logic [31:0] e1, input logic [31:0] e2);
      rd_en = 1'b1; rd_addr = a;
      dir_use = 1'b1; dir_exp[0] = e0; dir_exp[1] = e1; dir_exp[2] = e2;
      tick();
   endtask

   initial begin
      dir_exp[0] = '0; dir_exp[1] = '0; dir_exp[2] = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Known contents for addresses 0..15 (address 3 holds zero)
      for (int a = 0; a < 16; a++)
         do_wr(10'(a), (a == 3) ? 32'h0 : 32'h01010101 * 32'(a + 1), 4'hF);

      // Basic latency
      do_wr(10'd5, 32'hDEADBEEF, 4'hF);
      do_rd(10'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
      repeat (4) tick();

      // Partial write
      do_wr(10'd7, 32'h11223344, 4'hF);
      do_wr(10'd7, 32'hAABBCCDD, 4'b0101);
      do_rd(10'd7, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD);
      repeat (4) tick();

      // Collision, then read in the following cycle
      wr_en = 1'b1; wr_addr = 10'd3; wr_data = 32'hFFFFFFFF; wr_be = 4'b0011;
      do_rd(10'd3, 32'h0000FFFF, 32'h00000000, 32'h0000FFFF);
      do_rd(10'd3, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF);
      repeat (4) tick();

      // Out of range for the 12-deep configurations
      do_wr(10'd13, 32'h5A5A5A5A, 4'hF);
      do_rd(10'd13, 32'h5A5A5A5A, 32'h0, 32'h0);
      repeat (4) tick();

      // Streaming 0..15, then idle so data hold is observed
      for (int a = 0; a < 16; a++) begin
         rd_en = 1'b1; rd_addr = 10'(a);
         tick();
      end
      repeat (6) tick();

      // Reset mid-flight with an ignored write and read during reset
      rd_en = 1'b1; rd_addr = 10'd1; tick();
      rd_en = 1'b1; rd_addr = 10'd2; tick();
      rst = 1'b1; wr_en = 1'b1; wr_addr = 10'd4; wr_data = 32'h12345678; wr_be = 4'hF;
      rd_en = 1'b1; rd_addr = 10'd4;
      tick();
      repeat (4) tick();
      do_rd(10'd4, 32'h05050505, 32'h05050505, 32'h05050505);
      repeat (4) tick();

      // Randomized traffic with biased collisions and occasional reset
      for (int i = 0; i < 400; i++) begin
         rd_en   = ($urandom_range(0, 3) != 0);
         rd_addr = 10'($urandom_range(0, 15));
         wr_en   = ($urandom_range(0, 1) != 0);
         wr_addr = ($urandom_range(0, 2) == 0) ? rd_addr : 10'($urandom_range(0, 15));
         wr_data = $urandom;
         wr_be   = 4'($urandom_range(0, 15));
         rst     = ($urandom_range(0, 59) == 0);
         tick();
      end

      repeat (6) tick();
      done = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
